// File: rtl/key_extract_cfg_ctrl.sv
// Per-tenant extraction-config table and PHV issue pacer in front of key_extract.
// Optional feature: define KEYCTL_DROP_UNCFG_EN to drop PHVs whose tenant entry is invalid.
module key_extract_cfg_ctrl #(
    parameter int PHV_LEN    = 1579,
    parameter int COND_OFF   = 256,
    parameter int CONT_OFF   = 356,
    parameter int GAP_CYCLES = 1
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic               phv_in_valid,
    output logic               phv_in_ready,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic [3:0]         phv_tid,
    output logic               phv_out_valid,
    output logic [PHV_LEN-1:0] phv_out,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_addr,
    input  logic [211:0]       cfg_data,
    input  logic               cfg_clr,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        drop_cnt
);

    localparam int          ENTRY_W   = 212;
    localparam logic [19:0] MISS_COND = 20'hC0000;
    localparam logic [3:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ENTRY_W-1:0]   r_table [16];
    logic [15:0]          r_entry_vld;
    logic                 r_ready;
    logic                 r_out_valid;
    logic [PHV_LEN-1:0]   r_phv_out;
    logic [31:0]          r_pkt_cnt;
    logic [31:0]          r_drop_cnt;
    logic [3:0]           r_gap_cnt;

    logic                 w_accept;
    logic                 w_hit;
    logic                 w_issue;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_entry;

    function automatic logic [PHV_LEN-1:0] f_stamp(input logic [PHV_LEN-1:0] phv,
                                                   input logic [ENTRY_W-1:0] ent);
        logic [PHV_LEN-1:0] v;
        v = phv;
        v[CONT_OFF +: 192] = ent[211:20];
        v[COND_OFF +: 20]  = ent[19:0];
        return v;
    endfunction

    // r_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_accept = r_ready & phv_in_valid;
    assign w_hit    = r_entry_vld[phv_tid];
    assign w_entry  = w_hit ? r_table[phv_tid] : {192'd0, MISS_COND};

`ifdef KEYCTL_DROP_UNCFG_EN
    assign w_issue = w_accept & w_hit;
    assign w_drop  = w_accept & ~w_hit;
`else
    assign w_issue = w_accept;
    assign w_drop  = 1'b0;
`endif

    // Next-state decode for the issue pacer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) w_state_nxt = ST_ISSUE;
                else         w_state_nxt = ST_IDLE;
            end
            ST_ISSUE: begin
                if (GAP_CYCLES > 0) w_state_nxt = ST_GAP;
                else                w_state_nxt = ST_IDLE;
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) w_state_nxt = ST_IDLE;
                else                   w_state_nxt = ST_GAP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, handshake, issued PHV, gap counter and statistics
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_out_valid <= 1'b0;
            r_phv_out   <= {PHV_LEN{1'b0}};
            r_pkt_cnt   <= 32'd0;
            r_drop_cnt  <= 32'd0;
            r_gap_cnt   <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_out_valid <= w_issue;
            if (w_issue) begin
                r_phv_out <= f_stamp(phv_in, w_entry);
            end
            // count on leaving ISSUE so a PHV lost to reset is never counted
            if (r_state == ST_ISSUE) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (r_state == ST_ISSUE) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    // Entry valid bits; clear has priority over write
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_entry_vld <= 16'd0;
        end else if (cfg_clr) begin
            r_entry_vld[cfg_addr] <= 1'b0;
        end else if (cfg_wr) begin
            r_entry_vld[cfg_addr] <= 1'b1;
        end
    end

    // Entry payload storage, deliberately not reset
    always_ff @(posedge axis_clk) begin
        if (cfg_wr && !cfg_clr) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    assign phv_in_ready  = r_ready;
    assign phv_out_valid = r_out_valid;
    assign phv_out       = r_phv_out;
    assign pkt_cnt       = r_pkt_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_key_extract_cfg_ctrl.sv
// Self-checking bench for key_extract_cfg_ctrl: two instances (GAP_CYCLES=2 and 0)
// share stimulus; a per-instance behavioural model is checked every cycle.
module tb_key_extract_cfg_ctrl;

    localparam int PL = 1579;
`ifdef KEYCTL_DROP_UNCFG_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          valid = 1'b0;
    logic [PL-1:0] phv_in = '0;
    logic [3:0]    tid = 4'd0;
    logic          cfg_wr = 1'b0;
    logic          cfg_clr = 1'b0;
    logic [3:0]    cfg_addr = 4'd0;
    logic [211:0]  cfg_data = '0;

    logic          dut_rdy [2];
    logic          dut_ov  [2];
    logic [PL-1:0] dut_po  [2];
    logic [31:0]   dut_pkt [2];
    logic [31:0]   dut_drp [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    key_extract_cfg_ctrl #(.PHV_LEN(PL), .COND_OFF(256), .CONT_OFF(356), .GAP_CYCLES(2)) u_dut_g2 (
        .axis_clk(clk), .aresetn(aresetn), .phv_in_valid(valid), .phv_in_ready(dut_rdy[0]),
        .phv_in(phv_in), .phv_tid(tid), .phv_out_valid(dut_ov[0]), .phv_out(dut_po[0]),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_clr(cfg_clr),
        .pkt_cnt(dut_pkt[0]), .drop_cnt(dut_drp[0]));

    key_extract_cfg_ctrl #(.PHV_LEN(PL), .COND_OFF(256), .CONT_OFF(356), .GAP_CYCLES(0)) u_dut_g0 (
        .axis_clk(clk), .aresetn(aresetn), .phv_in_valid(valid), .phv_in_ready(dut_rdy[1]),
        .phv_in(phv_in), .phv_tid(tid), .phv_out_valid(dut_ov[1]), .phv_out(dut_po[1]),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_clr(cfg_clr),
        .pkt_cnt(dut_pkt[1]), .drop_cnt(dut_drp[1]));

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_phv(input string nm, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cond %h low %h expected cond %h low %h", nm,
                     act[256 +: 20], act[63:0], exp[256 +: 20], exp[63:0]);
        end
    endtask

    // Behavioural model: ready is a countdown of busy cycles after each issue
    logic [211:0]  m_tab [2][16];
    logic [15:0]   m_vld [2];
    logic          m_rdy [2];
    int            m_busy [2];
    logic          m_ov [2];
    logic [PL-1:0] m_po [2];
    logic [31:0]   m_pkt [2];
    logic [31:0]   m_drp [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int     g;
            logic   acc, hit, iss, drp;
            logic [211:0] ent;
            g = (k == 0) ? 2 : 0;
            if (!aresetn) begin
                m_vld[k] = '0; m_rdy[k] = 1'b0; m_busy[k] = 0; m_ov[k] = 1'b0;
                m_po[k] = '0; m_pkt[k] = '0; m_drp[k] = '0;
            end
            chk($sformatf("ready[%0d]", k), 192'(dut_rdy[k]), 192'(m_rdy[k]));
            chk($sformatf("out_valid[%0d]", k), 192'(dut_ov[k]), 192'(m_ov[k]));
            chk_phv($sformatf("phv_out[%0d]", k), dut_po[k], m_po[k]);
            chk($sformatf("pkt_cnt[%0d]", k), 192'(dut_pkt[k]), 192'(m_pkt[k]));
            chk($sformatf("drop_cnt[%0d]", k), 192'(dut_drp[k]), 192'(m_drp[k]));
            if (aresetn) begin
                acc = m_rdy[k] && valid;
                hit = m_vld[k][tid];
                ent = hit ? m_tab[k][tid] : {192'd0, 20'hC0000};
                iss = acc && (hit || !DROP);
                drp = acc && !hit && DROP;
                if (m_ov[k]) m_pkt[k] = m_pkt[k] + 32'd1;
                m_ov[k] = iss;
                if (iss) begin
                    m_po[k] = phv_in;
                    m_po[k][356 +: 192] = ent[211:20];
                    m_po[k][256 +: 20]  = ent[19:0];
                end
                if (drp) m_drp[k] = m_drp[k] + 32'd1;
                if (iss) m_busy[k] = g + 1;
                else if (m_busy[k] > 0) m_busy[k] = m_busy[k] - 1;
                m_rdy[k] = (m_busy[k] == 0);
                if (cfg_clr) m_vld[k][cfg_addr] = 1'b0;
                else if (cfg_wr) begin
                    m_vld[k][cfg_addr] = 1'b1;
                    m_tab[k][cfg_addr] = cfg_data;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [PL-1:0] rand_phv();
        logic [PL-1:0] v;
        for (int i = 0; i < PL; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Hold valid until the GAP_CYCLES=2 instance accepts; returns one cycle after acceptance
    task automatic send(input logic [3:0] t, input logic [PL-1:0] p);
        bit ok;
        ok = 1'b0;
        tid = t; phv_in = p; valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (dut_rdy[0]) ok = 1'b1;
            cyc(1);
        end
        valid = 1'b0; cfg_wr = 1'b0; cfg_clr = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: got ready=0 for 20 cycles expected ready=1");
        end
    endtask

    initial begin
        logic [PL-1:0] p, a, b;
        logic [191:0]  offs_0c;
        int            cnt2, cnt0, consec;
        logic          prev0;
        offs_0c = {24{8'h0C}};

        cyc(3);
        chk("reset_ready", 192'(dut_rdy[0]), 192'd0);
        chk("reset_pkt", 192'(dut_pkt[0]), 192'd0);
        aresetn = 1'b1;
        cyc(1);
        chk("ready_after_release", 192'(dut_rdy[0]), 192'd1);

        // Entry 3 hit: stamped fields, passthrough, single pulse, count
        cfg_wr = 1'b1; cfg_addr = 4'd3; cfg_data = {offs_0c, 20'h80A0C};
        cyc(1);
        cfg_wr = 1'b0;
        p = rand_phv();
        send(4'd3, p);
        chk("t1_valid", 192'(dut_ov[0]), 192'd1);
        chk("t1_offsets", dut_po[0][356 +: 192], offs_0c);
        chk("t1_cond", 192'(dut_po[0][256 +: 20]), 192'(20'h80A0C));
        a = dut_po[0]; a[356 +: 192] = '0; a[256 +: 20] = '0;
        b = p;         b[356 +: 192] = '0; b[256 +: 20] = '0;
        chk_phv("t1_passthrough", a, b);
        cyc(1);
        chk("t1_single_pulse", 192'(dut_ov[0]), 192'd0);
        chk("t1_pkt_cnt", 192'(dut_pkt[0]), 192'd1);
        cyc(4);

        // Continuous valid for 12 cycles on both pacing settings
        cnt2 = 0; cnt0 = 0; consec = 0; prev0 = 1'b0;
        tid = 4'd3; phv_in = rand_phv(); valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("gap2_ready_c%0d", c), 192'(dut_rdy[0]), 192'((c % 4) == 0));
            cnt2 += int'(dut_ov[0]);
            cnt0 += int'(dut_ov[1]);
            if (prev0 && dut_ov[1]) consec++;
            prev0 = dut_ov[1];
            cyc(1);
        end
        valid = 1'b0;
        chk("gap2_pulses", 192'(cnt2), 192'd3);
        chk("gap0_pulses", 192'(cnt0), 192'd6);
        chk("gap0_back_to_back", 192'(consec), 192'd0);
        cyc(5);

        // Same-cycle write and acceptance: old contents win, new ones next time
        cfg_wr = 1'b1; cfg_addr = 4'd5; cfg_data = {{24{8'h05}}, 20'h00002};
        cyc(1);
        cfg_wr = 1'b0;
        cyc(1);
        cfg_wr = 1'b1; cfg_data = {{24{8'h05}}, 20'h00001};
        send(4'd5, rand_phv());
        chk("wr_same_cycle_cond", 192'(dut_po[0][256 +: 20]), 192'(20'h00002));
        cyc(4);
        send(4'd5, rand_phv());
        chk("wr_next_cond", 192'(dut_po[0][256 +: 20]), 192'(20'h00001));
        cyc(4);

        // Unprogrammed tenant
        send(4'd9, rand_phv());
        if (DROP) begin
            chk("miss_no_pulse", 192'(dut_ov[0]), 192'd0);
            chk("miss_drop_cnt", 192'(dut_drp[0]), 192'd1);
        end else begin
            chk("miss_pulse", 192'(dut_ov[0]), 192'd1);
            chk("miss_cond", 192'(dut_po[0][256 +: 20]), 192'(20'hC0000));
            chk("miss_offsets", dut_po[0][356 +: 192], 192'd0);
            chk("miss_drop_cnt", 192'(dut_drp[0]), 192'd0);
        end
        cyc(4);

        // Reset during ISSUE
        send(4'd3, rand_phv());
        chk("rst_pre_valid", 192'(dut_ov[0]), 192'd1);
        aresetn = 1'b0;
        #1;
        chk("rst_valid", 192'(dut_ov[0]), 192'd0);
        chk("rst_ready", 192'(dut_rdy[0]), 192'd0);
        chk("rst_pkt", 192'(dut_pkt[0]), 192'd0);
        chk("rst_drop", 192'(dut_drp[0]), 192'd0);
        chk_phv("rst_phv_out", dut_po[0], '0);
        cyc(2);
        aresetn = 1'b1;
        cyc(2);
        send(4'd3, rand_phv());
        if (DROP) begin
            chk("post_rst_miss_drop", 192'(dut_drp[0]), 192'd1);
        end else begin
            chk("post_rst_miss_cond", 192'(dut_po[0][256 +: 20]), 192'(20'hC0000));
            chk("post_rst_miss_offs", dut_po[0][356 +: 192], 192'd0);
        end
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_extract_cfg_ctrl.md
# key_extract_cfg_ctrl

Per-tenant configuration controller and issue sequencer placed between the parser and `key_extract`. Holds a 16-entry table of extraction offsets (24 bytes) and condition words (20 bits), stamps the selected tenant's entry into each PHV, and paces `parser_valid` pulses to the rate `key_extract` can accept. The control plane writes entries at any time without stalling traffic.

## Interface
Parameters:
- `PHV_LEN`, 1579, PHV width in bits.
- `COND_OFF`, 256, LSB of the 20-bit condition field in the PHV.
- `CONT_OFF`, 356, LSB of the 192-bit offset block (8B, 4B, 2B offsets, 8 bytes each).
- `GAP_CYCLES`, 1, idle cycles forced after each issued PHV (0–15).

Ports:
- `axis_clk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `phv_in_valid` in 1: parser PHV valid.
- `phv_in_ready` out 1: controller accepts PHV.
- `phv_in` in PHV_LEN: parser PHV.
- `phv_tid` in 4: tenant ID of `phv_in`.
- `phv_out_valid` out 1: drives `key_extract.parser_valid`.
- `phv_out` out PHV_LEN: drives `key_extract.pkt_hdr_vec`.
- `cfg_wr` in 1: table write strobe.
- `cfg_addr` in 4: entry index.
- `cfg_data` in 212: [211:20] offsets block, [19:0] condition.
- `cfg_clr` in 1: invalidate entry `cfg_addr` (wins over `cfg_wr` in the same cycle).
- `pkt_cnt` out 32: PHVs issued, wraps.
- `drop_cnt` out 32: PHVs dropped, wraps.

## Operation
- Table: 16 × 212-bit entries plus 16 entry-valid bits. Reset clears all valid bits. Entry data is not reset.
- A write or clear updates the entry at the clock edge. A PHV accepted in the same cycle uses the pre-edge contents.
- FSM states:
  - IDLE: `phv_in_ready`=1. When `phv_in_valid`=1 the PHV is accepted. A hit goes to ISSUE; a miss goes to IDLE or ISSUE, see Configuration.
  - ISSUE: `phv_out_valid`=1 for exactly one cycle. `pkt_cnt`+1. Then go to GAP if `GAP_CYCLES`>0, else IDLE.
  - GAP: `phv_in_ready`=0. A 4-bit counter loads `GAP_CYCLES`−1 on entry and decrements. Go to IDLE when it reads 0.
- Stamping: `phv_out` = `phv_in` with `[CONT_OFF +: 192]` replaced by entry[211:20] and `[COND_OFF +: 20]` replaced by entry[19:0]. All other bits pass unchanged.
- `phv_out` is registered on acceptance and holds until the next acceptance.
- `phv_in_ready` is 0 in ISSUE and GAP. The parser must hold `phv_in` while `phv_in_valid`=1 and `phv_in_ready`=0.

## Timing
- Reset values: `phv_in_ready`=0 during reset and 1 in the first cycle after release; `phv_out_valid`=0, `phv_out`=0, `pkt_cnt`=0, `drop_cnt`=0. State is IDLE.
- Latency: accept at edge N, `phv_out_valid` high in cycle N+1 only.
- Throughput: one PHV per 2+`GAP_CYCLES` cycles. With `GAP_CYCLES`=0 the spacing is 2 cycles, which matches the `key_extract` IDLE/KEY cycle. No back-to-back `phv_out_valid` is ever produced.
- Reset asserted mid-ISSUE or mid-GAP: outputs return to reset values immediately. The in-flight PHV is lost and not counted.
- `cfg_wr` and `cfg_clr` are accepted every cycle with no backpressure.

## Configuration
- `KEYCTL_DROP_UNCFG_EN` defined: a PHV whose tenant entry is invalid is consumed in IDLE with no issue. `drop_cnt`+1 and the FSM stays in IDLE.
- `KEYCTL_DROP_UNCFG_EN` undefined: the PHV is issued with offsets = 0 and condition = 20'hC0000 (op 11, so `cond_flag` is true). `pkt_cnt`+1 and `drop_cnt` stays 0.

## Test plan
- Write entry 3 (offsets all 8'h0C, condition 20'h80A0C), then send a PHV with tid=3 → one cycle later `phv_out_valid`=1 for 1 cycle. `phv_out[356 +: 192]` = all 8'h0C, `phv_out[256 +: 20]`=20'h80A0C, remaining bits equal `phv_in`. `pkt_cnt`=1.
- `GAP_CYCLES`=2, `phv_in_valid` held high for 12 cycles → `phv_out_valid` pulses every 4 cycles (3 pulses), `phv_in_ready` pattern 1,0,0,0.
- `GAP_CYCLES`=0, continuous valid → pulses every 2 cycles and never two consecutive high cycles.
- Same-cycle `cfg_wr` to entry 5 (condition 20'h00001) and acceptance of a tid=5 PHV, old condition 20'h00002 → issued PHV carries 20'h00002. The next tid=5 PHV carries 20'h00001.
- Send a tid=9 PHV to an unprogrammed entry. With the macro: no pulse, `drop_cnt`=1. Without it: pulse with condition 20'hC0000 and offsets 0.
- Assert `aresetn` low in the cycle of ISSUE → `phv_out_valid` drops asynchronously, counters read 0, and after release a tid=3 PHV is treated as a miss (all valid bits cleared).
